// File: rtl/haze_pkg.sv
// Shared FSM state type, default frame geometry and border-flag layout for the
// haze-removal line-buffer controller.
package haze_pkg;

    localparam int IMG_W_DEF  = 512;
    localparam int IMG_H_DEF  = 512;
    localparam int NUM_LB_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } lb_state_e;

    // Bit positions inside the {top,bottom,left,right} border vector.
    localparam int BORDER_TOP    = 3;
    localparam int BORDER_BOTTOM = 2;
    localparam int BORDER_LEFT   = 1;
    localparam int BORDER_RIGHT  = 0;

    function automatic logic [3:0] border_flags(
        input logic top,
        input logic bottom,
        input logic left,
        input logic right
    );
        logic [3:0] flags;
        flags                = 4'b0000;
        flags[BORDER_TOP]    = top;
        flags[BORDER_BOTTOM] = bottom;
        flags[BORDER_LEFT]   = left;
        flags[BORDER_RIGHT]  = right;
        return flags;
    endfunction

endpackage

// File: rtl/lb_ctrl_coord_cnt.sv
// Enabled raster counter: column wraps at W-1 and advances the row, row wraps
// at H-1. Exposes column-last and row-last flags for the controller.
module lb_ctrl_coord_cnt #(
    parameter int W = 8,
    parameter int H = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clr,
    input  logic                 i_en,
    output logic [$clog2(W)-1:0] o_col,
    output logic [$clog2(H)-1:0] o_row,
    output logic                 o_col_last,
    output logic                 o_row_last
);

    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_col_last = (r_col == CW'(W - 1));
    assign o_row_last = (r_row == RW'(H - 1));

    // Raster position update with frame-start clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (o_col_last) begin
                r_col <= '0;
                r_row <= o_row_last ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer ring sequencer for the 3x3 window stage. Define LB_CTRL_FLUSH_EN
// to append IMG_W+1 synthetic flush beats so every pixel gets a window.
module line_buffer_ctrl
    import haze_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int NUM_LB = NUM_LB_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic [NUM_LB-1:0]         lb_wr_en,
    output logic [$clog2(NUM_LB)-1:0] lb_rd_sel,
    output logic                      flush,
    output logic                      win_valid,
    output logic [$clog2(IMG_H)-1:0]  win_row,
    output logic [$clog2(IMG_W)-1:0]  win_col,
    output logic [3:0]                border,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int SEL_W = $clog2(NUM_LB);

    lb_state_e         r_state;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_win_valid;
    logic [NUM_LB-1:0] r_lb_wr_en;
    logic [SEL_W-1:0]  r_lb_rd_sel;
    logic [ROW_W-1:0]  r_win_row;
    logic [COL_W-1:0]  r_win_col;
    logic [3:0]        r_border;

    logic              w_in_ready;
    logic              w_in_acc;
    logic              w_flush_beat;
    logic              w_win_fire;
    logic              w_in_en;
    logic              w_clr;
    logic [COL_W-1:0]  w_in_col;
    logic [ROW_W-1:0]  w_in_row;
    logic              w_in_col_last;
    logic              w_in_row_last;
    logic [COL_W-1:0]  w_win_col;
    logic [ROW_W-1:0]  w_win_row;
    logic              w_win_col_last;
    logic              w_win_row_last;

    // Input is only taken while the window stage can move, except while priming.
    assign w_in_ready = (r_state == ST_PRIME) | ((r_state == ST_STREAM) & out_ready);
    assign w_in_acc   = in_valid & w_in_ready;
`ifdef LB_CTRL_FLUSH_EN
    assign w_flush_beat = (r_state == ST_FLUSH) & out_ready;
`else
    assign w_flush_beat = 1'b0;
`endif
    assign w_win_fire = ((r_state == ST_STREAM) & w_in_acc) | w_flush_beat;
    assign w_in_en    = w_in_acc | w_flush_beat;
    assign w_clr      = (r_state == ST_IDLE) & start;

    lb_ctrl_coord_cnt #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_en       (w_in_en),
        .o_col      (w_in_col),
        .o_row      (w_in_row),
        .o_col_last (w_in_col_last),
        .o_row_last (w_in_row_last)
    );

    lb_ctrl_coord_cnt #(.W(IMG_W), .H(IMG_H)) u_win_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_en       (w_win_fire),
        .o_col      (w_win_col),
        .o_row      (w_win_row),
        .o_col_last (w_win_col_last),
        .o_row_last (w_win_row_last)
    );

    // Frame FSM plus the registered buffer-steering and window outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_valid  <= 1'b0;
            r_lb_wr_en   <= NUM_LB'(1);
            r_lb_rd_sel  <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_border     <= 4'b0000;
        end else begin
            r_frame_done <= 1'b0;
            r_win_valid  <= w_win_fire;
            if (w_win_fire) begin
                r_win_row <= w_win_row;
                r_win_col <= w_win_col;
                r_border  <= border_flags(w_win_row == '0, w_win_row_last,
                                          w_win_col == '0, w_win_col_last);
            end else begin
                r_border  <= 4'b0000;
            end

            // Each frame restarts on buffer 0 so frames replay identically.
            if (w_clr) begin
                r_lb_wr_en  <= NUM_LB'(1);
                r_lb_rd_sel <= SEL_W'(1);
            end else if (w_in_en && w_in_col_last) begin
                r_lb_wr_en  <= {r_lb_wr_en[NUM_LB-2:0], r_lb_wr_en[NUM_LB-1]};
                r_lb_rd_sel <= (r_lb_rd_sel == SEL_W'(NUM_LB - 1)) ? '0
                                                                    : r_lb_rd_sel + SEL_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (w_in_acc && (w_in_row == ROW_W'(1)) && (w_in_col == '0)) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (w_in_acc && w_in_col_last && w_in_row_last) begin
`ifdef LB_CTRL_FLUSH_EN
                        r_state      <= ST_FLUSH;
`else
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
`endif
                    end
                end
`ifdef LB_CTRL_FLUSH_EN
                ST_FLUSH: begin
                    if (w_flush_beat && w_win_col_last && w_win_row_last) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign flush      = w_flush_beat;
    assign lb_wr_en   = r_lb_wr_en;
    assign lb_rd_sel  = r_lb_rd_sel;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign border     = r_border;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
